// File: rtl/sand_step_engine.sv
// sand_step_engine: Avalon-MM master that runs one falling-sand physics step
// over a GRID_W x GRID_H byte-per-cell scene held in external memory.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   start                  one-cycle frame request, ignored while busy
//   busy                   high from the cycle after an accepted start until done
//   done                   one-cycle pulse at the end of a frame
//   frame_parity           sweep direction (0 = x ascending, 1 = x descending)
//   address/read/write     Avalon master command
//   waitrequest            Avalon stall
//   readdata/writedata     Avalon data
//
// Cell word: bits [1:0] type (0 EMPTY, 1 SAND, 2 WATER, 3 WALL), upper bits
// are payload that travels with the particle.
module sand_step_engine #(
  parameter int unsigned GRID_W    = 160,
  parameter int unsigned GRID_H    = 120,
  parameter int unsigned ADDR_W    = 23,
  parameter int unsigned CELL_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              frame_parity,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  input  logic [CELL_W-1:0] readdata,
  output logic [CELL_W-1:0] writedata
);

  localparam int unsigned X_W = (GRID_W > 2) ? $clog2(GRID_W) : 1;
  localparam int unsigned Y_W = (GRID_H > 2) ? $clog2(GRID_H) : 1;

  localparam logic [X_W-1:0]    X_LAST        = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]    Y_FIRST       = Y_W'(GRID_H - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] ROW_BASE_INIT = ADDR_W'(BASE_ADDR + (GRID_H - 2) * GRID_W);

  localparam logic [1:0] T_EMPTY = 2'd0;
  localparam logic [1:0] T_SAND  = 2'd1;
  localparam logic [1:0] T_WATER = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SELF,
    S_RD_DOWN,
    S_RD_DIAG_T,
    S_RD_DIAG_L,
    S_RD_SIDE_T,
    S_WR_DST,
    S_WR_SRC,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_row_base;
  logic [CELL_W-1:0]   r_src;
  logic                r_parity;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_address;
  logic                r_read;
  logic                r_write;
  logic [CELL_W-1:0]   r_writedata;

  logic [X_W-1:0]      w_x_trail;
  logic [X_W-1:0]      w_x_lead;
  logic [X_W-1:0]      w_x_row_start;
  logic                w_row_end;
  logic                w_trail_ok;
  logic                w_lead_ok;
  logic [ADDR_W-1:0]   w_addr_self;
  logic [ADDR_W-1:0]   w_addr_down;
  logic [ADDR_W-1:0]   w_addr_diag_t;
  logic [ADDR_W-1:0]   w_addr_diag_l;
  logic [ADDR_W-1:0]   w_addr_side_t;
  logic                w_rd_empty;
  logic                w_src_moves;
  logic                w_src_water;

  // Trailing side is the already-visited side; leading is the sweep direction.
  assign w_x_trail     = r_parity ? r_x + X_W'(1) : r_x - X_W'(1);
  assign w_x_lead      = r_parity ? r_x - X_W'(1) : r_x + X_W'(1);
  assign w_x_row_start = r_parity ? X_LAST : '0;
  assign w_row_end     = r_parity ? (r_x == '0) : (r_x == X_LAST);
  assign w_trail_ok    = r_parity ? (r_x != X_LAST) : (r_x != '0);
  assign w_lead_ok     = r_parity ? (r_x != '0) : (r_x != X_LAST);

  // Addresses come from the running row base; no multiplier needed.
  assign w_addr_self   = r_row_base + ADDR_W'(r_x);
  assign w_addr_down   = r_row_base + ROW_STEP + ADDR_W'(r_x);
  assign w_addr_diag_t = r_row_base + ROW_STEP + ADDR_W'(w_x_trail);
  assign w_addr_diag_l = r_row_base + ROW_STEP + ADDR_W'(w_x_lead);
  assign w_addr_side_t = r_row_base + ADDR_W'(w_x_trail);

  assign w_rd_empty    = (readdata[1:0] == T_EMPTY);
  assign w_src_moves   = (readdata[1:0] == T_SAND) || (readdata[1:0] == T_WATER);
  assign w_src_water   = (r_src[1:0] == T_WATER);

  // Sweep FSM. Each access state raises read/write once and holds the command
  // until waitrequest is low; after a winning read, r_address already holds
  // the destination, so WR_DST reuses it unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_row_base  <= '0;
      r_src       <= '0;
      r_parity    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_address   <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_writedata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_x        <= w_x_row_start;
            r_y        <= Y_FIRST;
            r_row_base <= ROW_BASE_INIT;
            r_state    <= S_RD_SELF;
          end
        end

        S_RD_SELF: begin
          if (!r_read) begin
            r_read    <= 1'b1;
            r_address <= w_addr_self;
          end else if (!waitrequest) begin
            r_read  <= 1'b0;
            r_src   <= readdata;
            r_state <= w_src_moves ? S_RD_DOWN : S_NEXT;
          end
        end

        S_RD_DOWN: begin
          if (!r_read) begin
            r_read    <= 1'b1;
            r_address <= w_addr_down;
          end else if (!waitrequest) begin
            r_read  <= 1'b0;
            r_state <= w_rd_empty ? S_WR_DST : S_RD_DIAG_T;
          end
        end

        S_RD_DIAG_T: begin
          if (!w_trail_ok) begin
            r_state <= S_RD_DIAG_L;
          end else if (!r_read) begin
            r_read    <= 1'b1;
            r_address <= w_addr_diag_t;
          end else if (!waitrequest) begin
            r_read  <= 1'b0;
            r_state <= w_rd_empty ? S_WR_DST : S_RD_DIAG_L;
          end
        end

        S_RD_DIAG_L: begin
          if (!w_lead_ok) begin
            r_state <= w_src_water ? S_RD_SIDE_T : S_NEXT;
          end else if (!r_read) begin
            r_read    <= 1'b1;
            r_address <= w_addr_diag_l;
          end else if (!waitrequest) begin
            r_read <= 1'b0;
            if (w_rd_empty)       r_state <= S_WR_DST;
            else if (w_src_water) r_state <= S_RD_SIDE_T;
            else                  r_state <= S_NEXT;
          end
        end

        S_RD_SIDE_T: begin
          if (!w_trail_ok) begin
            r_state <= S_NEXT;
          end else if (!r_read) begin
            r_read    <= 1'b1;
            r_address <= w_addr_side_t;
          end else if (!waitrequest) begin
            r_read  <= 1'b0;
            r_state <= w_rd_empty ? S_WR_DST : S_NEXT;
          end
        end

        S_WR_DST: begin
          if (!r_write) begin
            r_write     <= 1'b1;
            r_writedata <= r_src;
          end else if (!waitrequest) begin
            r_write <= 1'b0;
            r_state <= S_WR_SRC;
          end
        end

        S_WR_SRC: begin
          if (!r_write) begin
            r_write     <= 1'b1;
            r_address   <= w_addr_self;
            r_writedata <= '0;
          end else if (!waitrequest) begin
            r_write <= 1'b0;
            r_state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (w_row_end) begin
            if (r_y == '0) begin
              r_state <= S_DONE;
            end else begin
              r_y        <= r_y - Y_W'(1);
              r_row_base <= r_row_base - ROW_STEP;
              r_x        <= w_x_row_start;
              r_state    <= S_RD_SELF;
            end
          end else begin
            r_x     <= w_x_lead;
            r_state <= S_RD_SELF;
          end
        end

        S_DONE: begin
          r_done   <= 1'b1;
          r_parity <= ~r_parity;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign frame_parity = r_parity;
  assign address      = r_address;
  assign read         = r_read;
  assign write        = r_write;
  assign writedata    = r_writedata;

endmodule

// File: tb/tb_sand_step_engine.sv
// Scoreboarded bench for sand_step_engine on a 4x4 grid with a behavioural
// memory slave that can stall each transfer.
module tb_sand_step_engine;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned N  = W * H;

  typedef struct {
    bit wr;
    int addr;
    int data;
  } xact_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          frame_parity;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic          waitrequest = 1'b0;
  logic [CW-1:0] readdata;
  logic [CW-1:0] writedata;

  logic [CW-1:0] mem [0:255];
  int            ref_mem [0:N-1];
  xact_t         exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit exp_parity = 1'b0;

  bit            in_xfer = 1'b0;
  bit            x_rd, x_wr;
  logic [AW-1:0] x_addr;
  logic [CW-1:0] x_data;
  int            stall_left = 0;
  bit            stall_en = 1'b0;
  bit            stall_force = 1'b0;
  bit            scb_en = 1'b1;
  bit            overlap, unstable, oob;

  sand_step_engine #(
    .GRID_W(W), .GRID_H(H), .ADDR_W(AW), .CELL_W(CW), .BASE_ADDR(0)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .frame_parity(frame_parity), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .readdata(readdata), .writedata(writedata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign readdata = mem[address];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_xact();
    xact_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL xact: unexpected wr=%0d addr=%0d data=0x%0h", x_wr, address, writedata);
    end else begin
      e = exp_q.pop_front();
      if (e.wr != x_wr || e.addr != int'(address) || (e.wr && e.data != int'(writedata))) begin
        n_errors++;
        $display("FAIL xact: got wr=%0d addr=%0d data=0x%0h expected wr=%0d addr=%0d data=0x%0h",
                 x_wr, address, writedata, e.wr, e.addr, e.data);
      end
    end
  endtask

  // Slave: latch each new command and decide how long to stall it.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      in_xfer     = 1'b0;
      waitrequest = 1'b0;
    end else begin
      if (!in_xfer && (read || write)) begin
        in_xfer = 1'b1;
        x_rd    = read;
        x_wr    = write;
        x_addr  = address;
        x_data  = writedata;
        if (int'(address) >= int'(N)) oob = 1'b1;
        if (stall_force && write) stall_left = 1000000;
        else if (stall_en)        stall_left = $urandom_range(0, 5);
        else                      stall_left = 0;
      end
      waitrequest = in_xfer && (stall_left != 0);
      if (waitrequest) stall_left--;
    end
  end

  // Monitor: complete transfers, compare against scoreboard, track protocol.
  always @(negedge clock) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (read && write) overlap = 1'b1;
      if (in_xfer) begin
        if (address != x_addr || read != x_rd || write != x_wr || (x_wr && writedata != x_data))
          unstable = 1'b1;
        if (!waitrequest) begin
          if (scb_en) check_xact();
          if (x_wr) mem[address] = writedata;
          in_xfer = 1'b0;
        end
      end
    end
  end

  function automatic void push(input bit wr, input int a, input int d);
    xact_t e;
    e.wr = wr; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  // Reference: one frame applied cell by cell to ref_mem, recording every access.
  task automatic model_frame(input bit par);
    for (int y = int'(H) - 2; y >= 0; y--) begin
      for (int k = 0; k < int'(W); k++) begin
        int x     = par ? int'(W) - 1 - k : k;
        int t     = par ? x + 1 : x - 1;
        int l     = par ? x - 1 : x + 1;
        int self  = y * int'(W) + x;
        int src   = ref_mem[self];
        int cx[4] = '{x, t, l, t};
        int cy[4] = '{y + 1, y + 1, y + 1, y};
        int n     = ((src & 3) == 2) ? 4 : 3;
        bit moved = 1'b0;
        push(1'b0, self, 0);
        if ((src & 3) == 1 || (src & 3) == 2) begin
          for (int i = 0; i < n; i++) begin
            if (!moved && cx[i] >= 0 && cx[i] < int'(W)) begin
              int a = cy[i] * int'(W) + cx[i];
              push(1'b0, a, 0);
              if ((ref_mem[a] & 3) == 0) begin
                push(1'b1, a, src);
                push(1'b1, self, 0);
                ref_mem[a]    = src;
                ref_mem[self] = 0;
                moved = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic clear_scene();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < int'(N); i++) ref_mem[i] = 0;
  endtask

  task automatic set_cell(input int x, input int y, input int v);
    mem[y * int'(W) + x]     = CW'(v);
    ref_mem[y * int'(W) + x] = v;
  endtask

  task automatic random_scene();
    for (int i = 0; i < int'(N); i++) begin
      int r = $urandom_range(0, 9);
      int t = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      int v = (t == 0) ? 0 : (($urandom_range(0, 63) << 2) | t);
      mem[i]     = CW'(v);
      ref_mem[i] = v;
    end
  endtask

  task automatic do_frame(input bit extra_start);
    int d0  = done_cnt;
    int cyc = 0;
    int bad = 0;
    overlap = 1'b0; unstable = 1'b0; oob = 1'b0;
    model_frame(exp_parity);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    if (extra_start) begin
      repeat (7) @(negedge clock);
      start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    while (done_cnt == d0 && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    if (done_cnt == d0) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end
    repeat (20) @(negedge clock);
    chk("done_pulses", done_cnt - d0, 1);
    chk("xacts_left", exp_q.size(), 0);
    exp_q.delete();
    exp_parity = ~exp_parity;
    chk("frame_parity", int'(frame_parity), int'(exp_parity));
    chk("busy_idle", int'(busy), 0);
    chk("protocol", int'({overlap, unstable, oob}), 0);
    for (int i = 0; i < int'(N); i++) if (int'(mem[i]) != ref_mem[i]) bad++;
    chk("mem_cells_wrong", bad, 0);
  endtask

  task automatic ensure_parity(input bit p);
    if (exp_parity != p) begin
      clear_scene();
      do_frame(1'b0);
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    clear_scene();
    repeat (3) @(negedge clock);
    chk("rst_address", int'(address), 0);
    chk("rst_read", int'(read), 0);
    chk("rst_write", int'(write), 0);
    chk("rst_writedata", int'(writedata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_parity", int'(frame_parity), 0);
    reset = 1'b0;

    // Fall, with a spurious start mid-frame on the second step.
    clear_scene();
    set_cell(1, 0, 8'h01);
    do_frame(1'b0);
    chk("fall1_dst", int'(mem[5]), 8'h01);
    chk("fall1_src", int'(mem[1]), 0);
    do_frame(1'b1);
    chk("fall2_dst", int'(mem[9]), 8'h01);
    do_frame(1'b0);
    do_frame(1'b0);
    chk("fall_rest", int'(mem[13]), 8'h01);

    // Diagonal to the trailing side, payload preserved.
    ensure_parity(1'b0);
    clear_scene();
    set_cell(1, 1, 3);
    set_cell(1, 0, 8'h41);
    do_frame(1'b0);
    chk("diag_dst", int'(mem[4]), 8'h41);
    chk("diag_src", int'(mem[1]), 0);

    // Water sideways, both parities.
    ensure_parity(1'b0);
    clear_scene();
    for (int x = 0; x < int'(W); x++) set_cell(x, 3, 3);
    set_cell(1, 2, 2); set_cell(2, 2, 3); set_cell(3, 2, 3);
    do_frame(1'b0);
    chk("water_left", int'(mem[8]), 8'h02);
    ensure_parity(1'b1);
    clear_scene();
    for (int x = 0; x < int'(W); x++) set_cell(x, 3, 3);
    set_cell(0, 2, 3); set_cell(1, 2, 3); set_cell(2, 2, 2);
    do_frame(1'b0);
    chk("water_right", int'(mem[11]), 8'h02);

    // Left edge: trailing neighbour is outside the grid.
    ensure_parity(1'b0);
    clear_scene();
    set_cell(0, 0, 1);
    set_cell(0, 1, 3);
    do_frame(1'b0);
    chk("edge_dst", int'(mem[5]), 8'h01);

    // Random scenes with random stalls.
    stall_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      if (f % 2 == 0) random_scene();
      do_frame(f == 5);
    end
    stall_en = 1'b0;

    // Reset while the first destination write is stalled.
    ensure_parity(1'b1);
    clear_scene();
    set_cell(1, 0, 8'h01);
    scb_en = 1'b0;
    stall_force = 1'b1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cyc = 0;
    while (!(write && waitrequest) && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    chk("wr_stall_seen", int'(write && waitrequest), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_read", int'(read), 0);
    chk("rst_mid_write", int'(write), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_parity", int'(frame_parity), 0);
    @(negedge clock);
    reset = 1'b0;
    stall_force = 1'b0;
    exp_q.delete();
    exp_parity = 1'b0;
    chk("rst_no_write_dst", int'(mem[5]), 0);
    chk("rst_no_write_src", int'(mem[1]), 8'h01);
    scb_en = 1'b1;
    clear_scene();
    set_cell(1, 0, 8'h01);
    do_frame(1'b0);
    chk("post_rst_dst", int'(mem[5]), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
